// File: rtl/mc_bus_pkg.sv
// Shared definitions for the two-port RAM arbiter: port ids and arbitration modes.
package mc_bus_pkg;

  // Identifies one of the two requesters sharing the RAM.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_e;

  // Arbitration modes selectable through the FIXED_PRIO parameter.
  localparam int unsigned PRIO_RR    = 0;
  localparam int unsigned PRIO_FIXED = 1;

  // Width of the RAM data path.
  localparam int unsigned DATA_W = 8;

  // Returns the port that is not p; round-robin hands the next contention to it.
  function automatic port_id_e other_port(input port_id_e p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage : mc_bus_pkg

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// Picks at most one requester per clock and registers its access onto the RAM bus.
// Round-robin, or port A priority with a starvation guard for port B.
module ram_arbiter
  import mc_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  n_reset,
  // port A (CPU)
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_W-1:0]     a_rdata,
  // port B
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_W-1:0]     b_rdata,
  // RAM side
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_W-1:0]     ram_din,
  input  logic [DATA_W-1:0]     ram_dout
);

  localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  // Registered state
  logic                  a_gnt_q,    a_gnt_d;
  logic                  b_gnt_q,    b_gnt_d;
  logic                  a_rvalid_q, a_rvalid_d;
  logic                  b_rvalid_q, b_rvalid_d;
  logic                  ram_we_q,   ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]     ram_din_q,  ram_din_d;
  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  port_id_e              last_grant_q, last_grant_d;

  // Arbitration decision for this edge
  logic a_elig, b_elig;
  logic a_win,  b_win;

  // A port granted last cycle sits out this edge, so a held req is never issued twice.
  assign a_elig = a_req & ~a_gnt_q;
  assign b_elig = b_req & ~b_gnt_q;

  // Winner selection: a lone eligible requester always wins; contention depends on mode.
  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    if (a_elig && b_elig) begin
      if (FIXED_PRIO == PRIO_FIXED) begin
        if (starve_cnt_q >= CNT_MAX) begin
          b_win = 1'b1;
        end else begin
          a_win = 1'b1;
        end
      end else begin
        if (other_port(last_grant_q) == PORT_B) begin
          b_win = 1'b1;
        end else begin
          a_win = 1'b1;
        end
      end
    end else begin
      a_win = a_elig;
      b_win = b_elig;
    end
  end

  // Next-state: issue the winner's access, track read returns and fairness state.
  always_comb begin
    a_gnt_d      = a_win;
    b_gnt_d      = b_win;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    last_grant_d = last_grant_q;
    starve_cnt_d = starve_cnt_q;

    if (a_win) begin
      ram_addr_d   = a_addr;
      ram_din_d    = a_wdata;
      ram_we_d     = a_we;
      last_grant_d = PORT_A;
    end else if (b_win) begin
      ram_addr_d   = b_addr;
      ram_din_d    = b_wdata;
      ram_we_d     = b_we;
      last_grant_d = PORT_B;
    end

    // The RAM returns data one cycle after the address; only reads report it.
    a_rvalid_d = a_gnt_q & ~ram_we_q;
    b_rvalid_d = b_gnt_q & ~ram_we_q;

    // Count edges where B could have gone but lost; reset when B is served or gives up.
    if (!b_req || b_win) begin
      starve_cnt_d = '0;
    end else if (b_elig && a_win && (starve_cnt_q < CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a_gnt_q      <= 1'b0;
      b_gnt_q      <= 1'b0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      starve_cnt_q <= '0;
      last_grant_q <= PORT_B;
    end else begin
      a_gnt_q      <= a_gnt_d;
      b_gnt_q      <= b_gnt_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      starve_cnt_q <= starve_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign a_gnt    = a_gnt_q;
  assign b_gnt    = b_gnt_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;

  // Both ports see the RAM output directly; rvalid says whose data it is.
  assign a_rdata  = ram_dout;
  assign b_rdata  = ram_dout;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: one round-robin and one fixed-priority instance, each with a RAM model.
// Read data expectations go through per-port scoreboards checked when rvalid pulses.
module tb_ram_arbiter;

  localparam int unsigned AW = 16;

  logic clk = 1'b0;
  logic n_reset;

  // Index 0: round-robin instance, index 1: fixed-priority instance
  logic          a_req [2], b_req [2], a_we [2], b_we [2];
  logic [AW-1:0] a_addr [2], b_addr [2];
  logic [7:0]    a_wdata [2], b_wdata [2];
  logic          a_gnt [2], b_gnt [2], a_rvalid [2], b_rvalid [2];
  logic [7:0]    a_rdata [2], b_rdata [2];
  logic          ram_we [2];
  logic [AW-1:0] ram_addr [2];
  logic [7:0]    ram_din [2];
  logic [7:0]    ram_dout [2];

  logic [7:0]    mem0 [0:65535];
  logic [7:0]    mem1 [0:65535];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [7:0]    pre_data;

  logic [7:0] qa0 [$];
  logic [7:0] qb0 [$];
  logic [7:0] qa1 [$];
  logic [7:0] qb1 [$];

  int n_tests;
  int n_fail;
  int waited;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(0), .MAX_WAIT(8)) u_rr (
    .clk(clk), .n_reset(n_reset),
    .a_req(a_req[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
    .a_gnt(a_gnt[0]), .a_rvalid(a_rvalid[0]), .a_rdata(a_rdata[0]),
    .b_req(b_req[0]), .b_we(b_we[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
    .b_gnt(b_gnt[0]), .b_rvalid(b_rvalid[0]), .b_rdata(b_rdata[0]),
    .ram_we(ram_we[0]), .ram_addr(ram_addr[0]), .ram_din(ram_din[0]), .ram_dout(ram_dout[0])
  );

  ram_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(1), .MAX_WAIT(8)) u_fp (
    .clk(clk), .n_reset(n_reset),
    .a_req(a_req[1]), .a_we(a_we[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
    .a_gnt(a_gnt[1]), .a_rvalid(a_rvalid[1]), .a_rdata(a_rdata[1]),
    .b_req(b_req[1]), .b_we(b_we[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
    .b_gnt(b_gnt[1]), .b_rvalid(b_rvalid[1]), .b_rdata(b_rdata[1]),
    .ram_we(ram_we[1]), .ram_addr(ram_addr[1]), .ram_din(ram_din[1]), .ram_dout(ram_dout[1])
  );

  // Synchronous RAM models with a side port for preloading
  always @(posedge clk) begin
    if (pre_we) begin
      mem0[pre_addr] <= pre_data;
      mem1[pre_addr] <= pre_data;
    end
    if (ram_we[0]) mem0[ram_addr[0]] <= ram_din[0];
    if (ram_we[1]) mem1[ram_addr[1]] <= ram_din[1];
    ram_dout[0] <= mem0[ram_addr[0]];
    ram_dout[1] <= mem1[ram_addr[1]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] addr, input logic [7:0] data);
    pre_addr = addr;
    pre_data = data;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Scoreboard and bus-rule monitor
  always @(negedge clk) begin
    if (a_rvalid[0]) begin
      chk("a0_rv_expected", 32'(qa0.size() != 0), 32'd1);
      if (qa0.size() != 0) chk("a0_rdata", 32'(a_rdata[0]), 32'(qa0.pop_front()));
    end
    if (b_rvalid[0]) begin
      chk("b0_rv_expected", 32'(qb0.size() != 0), 32'd1);
      if (qb0.size() != 0) chk("b0_rdata", 32'(b_rdata[0]), 32'(qb0.pop_front()));
    end
    if (a_rvalid[1]) begin
      chk("a1_rv_expected", 32'(qa1.size() != 0), 32'd1);
      if (qa1.size() != 0) chk("a1_rdata", 32'(a_rdata[1]), 32'(qa1.pop_front()));
    end
    if (b_rvalid[1]) begin
      chk("b1_rv_expected", 32'(qb1.size() != 0), 32'd1);
      if (qb1.size() != 0) chk("b1_rdata", 32'(b_rdata[1]), 32'(qb1.pop_front()));
    end
    for (int d = 0; d < 2; d++) begin
      if (ram_we[d]) chk("we_needs_gnt", 32'(a_gnt[d] | b_gnt[d]), 32'd1);
      if (a_gnt[d] || b_gnt[d]) chk("gnt_onehot", 32'(a_gnt[d] & b_gnt[d]), 32'd0);
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    n_reset  = 1'b0;
    pre_we   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    for (int d = 0; d < 2; d++) begin
      a_req[d] = 1'b0; b_req[d] = 1'b0; a_we[d] = 1'b0; b_we[d] = 1'b0;
      a_addr[d] = '0; b_addr[d] = '0; a_wdata[d] = '0; b_wdata[d] = '0;
    end

    preload(16'h1234, 8'hA5);
    preload(16'h0010, 8'h3C);
    preload(16'h0055, 8'h00);

    // Reset state
    for (int d = 0; d < 2; d++) begin
      chk("rst_flags", 32'({a_gnt[d], b_gnt[d], a_rvalid[d], b_rvalid[d], ram_we[d]}), 32'd0);
      chk("rst_addr", 32'(ram_addr[d]), 32'd0);
      chk("rst_din", 32'(ram_din[d]), 32'd0);
    end
    n_reset = 1'b1;

    // Single A read on the round-robin instance
    a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 16'h1234;
    qa0.push_back(8'hA5);
    cyc();
    chk("rd_a_gnt", 32'(a_gnt[0]), 32'd1);
    chk("rd_b_gnt", 32'(b_gnt[0]), 32'd0);
    chk("rd_addr", 32'(ram_addr[0]), 32'h1234);
    chk("rd_we", 32'(ram_we[0]), 32'd0);
    a_req[0] = 1'b0;
    cyc();
    chk("rd_a_rvalid", 32'(a_rvalid[0]), 32'd1);
    chk("rd_b_rvalid", 32'(b_rvalid[0]), 32'd0);
    chk("rd_a_gnt_off", 32'(a_gnt[0]), 32'd0);

    // A writes 0x3C to 0x0010, then B reads it back
    a_req[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 16'h0010; a_wdata[0] = 8'h3C;
    cyc();
    chk("wr_a_gnt", 32'(a_gnt[0]), 32'd1);
    chk("wr_we", 32'(ram_we[0]), 32'd1);
    chk("wr_din", 32'(ram_din[0]), 32'h3C);
    chk("wr_addr", 32'(ram_addr[0]), 32'h0010);
    a_req[0] = 1'b0; a_we[0] = 1'b0;
    b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 16'h0010;
    qb0.push_back(8'h3C);
    cyc();
    chk("wr_b_gnt", 32'(b_gnt[0]), 32'd1);
    chk("wr_we_read", 32'(ram_we[0]), 32'd0);
    chk("wr_no_rvalid", 32'(a_rvalid[0]), 32'd0);
    b_req[0] = 1'b0;
    cyc();
    chk("wr_b_rvalid", 32'(b_rvalid[0]), 32'd1);
    chk("wr_we_idle", 32'(ram_we[0]), 32'd0);

    // Round-robin contention; last grant was B so A goes first
    a_addr[0] = 16'h1234; b_addr[0] = 16'h0010;
    a_req[0] = 1'b1; b_req[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) qa0.push_back(8'hA5);
      else            qb0.push_back(8'h3C);
      cyc();
      chk("rr_a_gnt", 32'(a_gnt[0]), 32'(i % 2 == 0));
      chk("rr_b_gnt", 32'(b_gnt[0]), 32'(i % 2 == 1));
    end
    a_req[0] = 1'b0; b_req[0] = 1'b0;
    cyc();
    chk("idle_gnt", 32'({a_gnt[0], b_gnt[0]}), 32'd0);
    chk("idle_we", 32'(ram_we[0]), 32'd0);
    chk("idle_addr_hold", 32'(ram_addr[0]), 32'h0010);
    a_req[0] = 1'b1; b_req[0] = 1'b1;
    qa0.push_back(8'hA5);
    cyc();
    chk("rr_after_b", 32'({a_gnt[0], b_gnt[0]}), 32'b10);
    a_req[0] = 1'b0; b_req[0] = 1'b0;
    cyc();
    a_req[0] = 1'b1; b_req[0] = 1'b1;
    qb0.push_back(8'h3C);
    cyc();
    chk("rr_after_a", 32'({a_gnt[0], b_gnt[0]}), 32'b01);
    a_req[0] = 1'b0; b_req[0] = 1'b0;
    cyc();

    // Reset in the a_gnt cycle of a read
    a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 16'h1234;
    cyc();
    chk("mrst_gnt_before", 32'(a_gnt[0]), 32'd1);
    n_reset = 1'b0;
    #1;
    chk("mrst_gnt_cleared", 32'(a_gnt[0]), 32'd0);
    chk("mrst_addr_cleared", 32'(ram_addr[0]), 32'd0);
    cyc();
    chk("mrst_no_rvalid", 32'(a_rvalid[0]), 32'd0);
    n_reset = 1'b1;
    qa0.push_back(8'hA5);
    cyc();
    chk("mrst_fresh_gnt", 32'(a_gnt[0]), 32'd1);
    chk("mrst_fp_no_gnt", 32'({a_gnt[1], b_gnt[1]}), 32'd0);
    a_req[0] = 1'b0;
    cyc();
    chk("mrst_rvalid", 32'(a_rvalid[0]), 32'd1);

    // Fixed priority: B write pulses one cycle, loses to A, and is cancelled
    a_req[1] = 1'b1; a_we[1] = 1'b0; a_addr[1] = 16'h1234;
    b_req[1] = 1'b1; b_we[1] = 1'b1; b_addr[1] = 16'h0055; b_wdata[1] = 8'h77;
    qa1.push_back(8'hA5);
    cyc();
    chk("cxl_a_gnt", 32'(a_gnt[1]), 32'd1);
    chk("cxl_b_gnt", 32'(b_gnt[1]), 32'd0);
    chk("cxl_we", 32'(ram_we[1]), 32'd0);
    a_req[1] = 1'b0; b_req[1] = 1'b0; b_we[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("cxl_b_gnt_after", 32'(b_gnt[1]), 32'd0);
      chk("cxl_we_after", 32'(ram_we[1]), 32'd0);
    end
    // The cancelled write must not have reached 0x0055
    b_req[1] = 1'b1; b_addr[1] = 16'h0055;
    qb1.push_back(8'h00);
    cyc();
    chk("cxl_rb_gnt", 32'(b_gnt[1]), 32'd1);
    b_req[1] = 1'b0;
    cyc();

    // Fixed priority with both held: A first, B within 9 cycles, then A again
    a_req[1] = 1'b1; a_addr[1] = 16'h1234;
    b_req[1] = 1'b1; b_addr[1] = 16'h0010;
    qa1.push_back(8'hA5);
    cyc();
    chk("fp_a_first", 32'({a_gnt[1], b_gnt[1]}), 32'b10);
    waited = 1;
    while (!b_gnt[1] && waited < 9) begin
      cyc();
      waited++;
    end
    chk("fp_b_within9", 32'(b_gnt[1]), 32'd1);
    chk("fp_b_wait", 32'(waited), 32'd2);
    qb1.push_back(8'h3C);
    qa1.push_back(8'hA5);
    cyc();
    chk("fp_a_resume", 32'({a_gnt[1], b_gnt[1]}), 32'b10);
    a_req[1] = 1'b0; b_req[1] = 1'b0;
    cyc();
    cyc();
    cyc();

    chk("sb_a0_empty", 32'(qa0.size()), 32'd0);
    chk("sb_b0_empty", 32'(qb0.size()), 32'd0);
    chk("sb_a1_empty", 32'(qa1.size()), 32'd0);
    chk("sb_b1_empty", 32'(qb1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ram_arbiter

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, RAM address width.
REQ-002 SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin; 1 = port A (CPU) priority with a starvation guard.
REQ-003 SHALL have parameter MAX_WAIT, default 8, the number of cycles port B may be refused before it is forced to win (FIXED_PRIO=1 only).
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 n_reset  in  1  asynchronous, active-low reset.
REQ-006 a_req, b_req  in  1 each  access request; the requester holds it high until it sees the matching gnt.
REQ-007 a_we, b_we  in  1 each  1 = write, 0 = read; qualified by req.
REQ-008 a_addr, b_addr  in  ADDR_WIDTH each  access address.
REQ-009 a_wdata, b_wdata  in  8 each  write data.
REQ-010 a_gnt, b_gnt  out  1 each  one-cycle pulse: the access was issued to the RAM.
REQ-011 a_rvalid, b_rvalid  out  1 each  one-cycle pulse: read data valid.
REQ-012 a_rdata, b_rdata  out  8 each  read data; both are driven from ram_dout.
REQ-013 ram_we  out  1  RAM write enable.
REQ-014 ram_addr  out  ADDR_WIDTH  RAM address.
REQ-015 ram_din  out  8  RAM write data.
REQ-016 ram_dout  in  8  synchronous RAM read data, valid one cycle after the address is presented.

Function
REQ-017 At each posedge the block SHALL sample the eligible requests and pick at most one winner; it SHALL register that winner's addr/wdata/we onto ram_addr/ram_din/ram_we and pulse its gnt for exactly that following cycle.
REQ-018 A port whose gnt is high SHALL be ineligible at the next edge, so each port gets at most one access per 2 cycles and a held req is never double-issued.
REQ-019 ram_we SHALL be high only in a cycle where a gnt is high and the granted request was a write; it is low in all other cycles.
REQ-020 Read latency: x_rvalid SHALL pulse the cycle after x_gnt for a read, and x_rdata = ram_dout in that cycle; writes produce no rvalid.
REQ-021 Round-robin (FIXED_PRIO=0): with both eligible, the winner SHALL be the port other than last_grant; last_grant updates only on a grant.
REQ-022 Fixed priority (FIXED_PRIO=1): A SHALL win whenever it is eligible, except when starve_cnt >= MAX_WAIT, in which case B wins.
REQ-023 starve_cnt SHALL increment (saturating at MAX_WAIT) each edge where b_req is eligible but B loses; it clears on b_gnt or when b_req is low.
REQ-024 With only one eligible requester, that requester SHALL win regardless of mode.
REQ-025 In an idle cycle (no winner), ram_addr SHALL hold its last value and ram_we SHALL be 0.
REQ-026 Dropping req before gnt SHALL cancel the request with no side effects.

Reset
REQ-027 While n_reset is low, all gnt, rvalid and ram_we outputs SHALL be 0, ram_addr and ram_din 0, starve_cnt 0, and last_grant = B, so A wins the first contention.
REQ-028 Reset asserted mid-access SHALL suppress any pending rvalid, and no grant SHALL issue at the first edge after release unless req is sampled high at that edge.

Structure
REQ-029 Shared package mc_bus_pkg SHALL hold the port-id enum (PORT_A, PORT_B) and the FIXED_PRIO mode constants.
REQ-030 SHALL be a single module with no sub-module; all arbitration state lives in registers of this block.

Verification
REQ-031 Single A read: preload mem[0x1234]=0xA5; a_req=1, a_we=0, a_addr=0x1234 -> a_gnt in cycle N, a_rvalid in N+1 with a_rdata=0xA5, b_* stay 0.
REQ-032 RR contention: FIXED_PRIO=0, a_req and b_req held high for 8 cycles -> grants A,B,A,B..., never two consecutive gnts to the same port.
REQ-033 Starvation: FIXED_PRIO=1, MAX_WAIT=8, A requests continuously, b_req held high -> b_gnt within 9 cycles of b_req, then A resumes winning.
REQ-034 Write then read: A writes 0x3C to 0x0010, then B reads 0x0010 -> ram_we high only in the a_gnt cycle, b_rdata=0x3C.
REQ-035 Reset mid-read: n_reset low in the a_gnt cycle -> no a_rvalid; after release with a_req held, a fresh a_gnt arrives one edge later.
REQ-036 Cancel: b_req pulses 1 cycle while it loses to A -> no b_gnt and no RAM write.
